// File: rtl/fetch_unit.sv
// Instruction fetch engine: line-sized Sysbus reads unpacked into an instruction FIFO with PCs.
// Optional FETCH_PERF_EN adds saturating perf_lines/perf_stall counters.
module fetch_unit #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int INSN_WIDTH     = 32,
    parameter int LINE_BYTES     = 64,
    parameter int FIFO_DEPTH     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [63:0]               entry,
    input  logic                      redirect_valid,
    input  logic [63:0]               redirect_pc,
    output logic                      insn_valid,
    input  logic                      insn_ready,
    output logic [INSN_WIDTH-1:0]     insn,
    output logic [63:0]               insn_pc,
    output logic                      halted,
    output logic                      bus_reqcyc,
    input  logic                      bus_reqack,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_respcyc,
    output logic                      bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]               perf_lines,
    output logic [31:0]               perf_stall
`endif
);

    localparam int WPB    = BUS_DATA_WIDTH / INSN_WIDTH;
    localparam int BPL    = LINE_BYTES * 8 / BUS_DATA_WIDTH;
    localparam int WPL    = LINE_BYTES * 8 / INSN_WIDTH;
    localparam int BEAT_W = (BPL > 1) ? $clog2(BPL) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int ENQ_W  = $clog2(WPB + 1);

    localparam logic [63:0] LINE_MASK  = ~(64'(LINE_BYTES) - 64'd1);
    localparam logic [63:0] BEAT_BYTES = 64'(BUS_DATA_WIDTH / 8);
    localparam logic [63:0] WORD_BYTES = 64'(INSN_WIDTH / 8);
    localparam logic [3:0]  SYSBUS_READ   = 4'd1;
    localparam logic [3:0]  SYSBUS_MEMORY = 4'd1;
    localparam logic [BUS_TAG_WIDTH-1:0] READ_TAG =
        BUS_TAG_WIDTH'((32'(SYSBUS_READ) << 8) | (32'(SYSBUS_MEMORY) << 12));

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]               state_q, state_d;
    logic                     boot_q, boot_d;
    logic [63:0]              fetch_pc_q, fetch_pc_d;
    logic [63:0]              line_base_q, line_base_d;
    logic [BUS_TAG_WIDTH-1:0] tag_q, tag_d;
    logic [BEAT_W-1:0]        beat_q, beat_d;
    logic                     stale_q, stale_d;
    logic                     halt_pend_q, halt_pend_d;
    logic                     halted_q, halted_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     out_valid_q, out_valid_d;
    logic [INSN_WIDTH-1:0]    out_insn_q, out_insn_d;
    logic [63:0]              out_pc_q, out_pc_d;
    logic [INSN_WIDTH-1:0]    mem_insn_q [FIFO_DEPTH];
    logic [63:0]              mem_pc_q   [FIFO_DEPTH];

    logic [63:0]              fetch_pc_s;
    logic [CNT_W-1:0]         free_s;
    logic [CNT_W-1:0]         remain_s;
    logic                     beat_fire_s;
    logic                     last_beat_s;
    logic                     pop_s;
    logic                     stop_s;
    logic                     halt_seen_s;
    logic [ENQ_W-1:0]         enq_n_s;
    logic [INSN_WIDTH-1:0]    head_insn_s;
    logic [63:0]              head_pc_s;
    logic                     we_s   [WPB];
    logic [PTR_W-1:0]         slot_s [WPB];
    logic [INSN_WIDTH-1:0]    word_s [WPB];
    logic [63:0]              wpc_s  [WPB];
    logic                     unused_s;

    // The entry input stands in for the fetch PC until the first clock after reset.
    assign fetch_pc_s  = boot_q ? entry : fetch_pc_q;
    assign free_s      = CNT_W'(FIFO_DEPTH) - count_q;
    assign beat_fire_s = (state_q == ST_RESP) && bus_respcyc;
    assign last_beat_s = beat_fire_s && (beat_q == BEAT_W'(BPL - 1));
    assign pop_s       = out_valid_q && insn_ready;
    assign remain_s    = count_q - CNT_W'(pop_s);
    assign unused_s    = ^bus_resptag;

    // Unpack a response beat into compacted FIFO writes; a zero word truncates the line.
    always_comb begin
        enq_n_s     = '0;
        stop_s      = halt_pend_q;
        halt_seen_s = 1'b0;
        head_insn_s = '0;
        head_pc_s   = 64'd0;
        for (int k = 0; k < WPB; k++) begin
            word_s[k] = bus_resp[k*INSN_WIDTH +: INSN_WIDTH];
            wpc_s[k]  = line_base_q + 64'(beat_q) * BEAT_BYTES + 64'(k) * WORD_BYTES;
            slot_s[k] = wr_ptr_q + PTR_W'(enq_n_s);
            we_s[k]   = 1'b0;
            if (beat_fire_s && !stale_q && !redirect_valid && !stop_s && (wpc_s[k] >= fetch_pc_s)) begin
                if (word_s[k] == '0) begin
                    stop_s      = 1'b1;
                    halt_seen_s = 1'b1;
                end else begin
                    we_s[k] = 1'b1;
                    if (enq_n_s == '0) begin
                        head_insn_s = word_s[k];
                        head_pc_s   = wpc_s[k];
                    end else begin
                        head_insn_s = head_insn_s;
                    end
                    enq_n_s = enq_n_s + ENQ_W'(1);
                end
            end else begin
                we_s[k] = 1'b0;
            end
        end
    end

    // Request FSM and fetch PC; space for a full line is reserved before requesting.
    always_comb begin
        state_d     = state_q;
        boot_d      = 1'b0;
        fetch_pc_d  = fetch_pc_s;
        line_base_d = line_base_q;
        tag_d       = tag_q;
        beat_d      = beat_q;
        stale_d     = stale_q;
        case (state_q)
            ST_IDLE: begin
                if (!redirect_valid && !halt_pend_q && (free_s >= CNT_W'(WPL))) begin
                    state_d     = ST_REQ;
                    line_base_d = fetch_pc_s & LINE_MASK;
                    tag_d       = READ_TAG;
                    stale_d     = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus_reqack) begin
                    state_d = ST_RESP;
                    beat_d  = '0;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_RESP: begin
                if (beat_fire_s) begin
                    beat_d = beat_q + BEAT_W'(1);
                end else begin
                    beat_d = beat_q;
                end
                if (last_beat_s) begin
                    state_d = ST_IDLE;
                    if (!stale_q) begin
                        fetch_pc_d = line_base_q + 64'(LINE_BYTES);
                    end else begin
                        fetch_pc_d = fetch_pc_s;
                    end
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            stale_d    = (state_q == ST_REQ) || (state_q == ST_RESP);
        end else begin
            stale_d = stale_d;
        end
    end

    // FIFO pointers, registered head and halt tracking; redirect wins over enqueue/dequeue.
    always_comb begin
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop_s);
        wr_ptr_d    = wr_ptr_q + PTR_W'(enq_n_s);
        count_d     = remain_s + CNT_W'(enq_n_s);
        out_insn_d  = out_insn_q;
        out_pc_d    = out_pc_q;
        halt_pend_d = halt_pend_q | halt_seen_s;
        if (redirect_valid) begin
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            halt_pend_d = 1'b0;
        end else if (remain_s != '0) begin
            out_insn_d = mem_insn_q[rd_ptr_d];
            out_pc_d   = mem_pc_q[rd_ptr_d];
        end else if (enq_n_s != '0) begin
            out_insn_d = head_insn_s;
            out_pc_d   = head_pc_s;
        end else begin
            out_insn_d = out_insn_q;
        end
        out_valid_d = (count_d != '0);
        if (redirect_valid) begin
            halted_d = 1'b0;
        end else begin
            halted_d = halted_q | (halt_pend_d && (count_d == '0));
        end
    end

    // FIFO storage needs no reset: only entries below count are ever read.
    always_ff @(posedge clk) begin
        for (int k = 0; k < WPB; k++) begin
            if (we_s[k]) begin
                mem_insn_q[slot_s[k]] <= word_s[k];
                mem_pc_q[slot_s[k]]   <= wpc_s[k];
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            boot_q      <= 1'b1;
            fetch_pc_q  <= 64'd0;
            line_base_q <= 64'd0;
            tag_q       <= '0;
            beat_q      <= '0;
            stale_q     <= 1'b0;
            halt_pend_q <= 1'b0;
            halted_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_insn_q  <= '0;
            out_pc_q    <= 64'd0;
        end else begin
            state_q     <= state_d;
            boot_q      <= boot_d;
            fetch_pc_q  <= fetch_pc_d;
            line_base_q <= line_base_d;
            tag_q       <= tag_d;
            beat_q      <= beat_d;
            stale_q     <= stale_d;
            halt_pend_q <= halt_pend_d;
            halted_q    <= halted_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_insn_q  <= out_insn_d;
            out_pc_q    <= out_pc_d;
        end
    end

    assign insn_valid  = out_valid_q;
    assign insn        = out_insn_q;
    assign insn_pc     = out_pc_q;
    assign halted      = halted_q;
    assign bus_reqcyc  = (state_q == ST_REQ);
    assign bus_req     = BUS_DATA_WIDTH'(line_base_q);
    assign bus_reqtag  = tag_q;
    assign bus_respack = (state_q == ST_RESP) && bus_respcyc;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_lines_q;
    logic [31:0] perf_stall_q;

    // Saturating counters: completed non-stale lines and decoder-starved cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_lines_q <= 32'd0;
            perf_stall_q <= 32'd0;
        end else begin
            if (last_beat_s && !stale_q && !redirect_valid && (perf_lines_q != 32'hFFFF_FFFF)) begin
                perf_lines_q <= perf_lines_q + 32'd1;
            end
            if (insn_ready && !out_valid_q && !halted_q && (perf_stall_q != 32'hFFFF_FFFF)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_lines = perf_lines_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a Sysbus memory responder, a transfer collector and hand-computed checks.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] entry;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        insn_valid;
    logic        insn_ready;
    logic [31:0] insn;
    logic [63:0] insn_pc;
    logic        halted;
    logic        bus_reqcyc;
    logic        bus_reqack;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_respcyc;
    logic        bus_respack;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_lines;
    logic [31:0] perf_stall;
`endif

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .reset(reset), .entry(entry),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .insn_valid(insn_valid), .insn_ready(insn_ready), .insn(insn), .insn_pc(insn_pc),
        .halted(halted),
        .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_respcyc(bus_respcyc), .bus_respack(bus_respack), .bus_resp(bus_resp),
        .bus_resptag(bus_resptag)
`ifdef FETCH_PERF_EN
        , .perf_lines(perf_lines), .perf_stall(perf_stall)
`endif
    );

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] zero_addr = '1;
    logic [63:0] req_q [$];
    logic [63:0] tag_q [$];
    logic [63:0] pcs   [$];
    logic [63:0] ins   [$];
    logic        busy;
    int          beat;
    logic [63:0] line_addr;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Memory image: word at address a is a/4 - 0x3FF (0x1000 holds 1), except the planted zero.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == zero_addr) return 32'h0;
        return 32'(a >> 2) - 32'h3FF;
    endfunction

    function automatic logic [63:0] beat_data(input logic [63:0] base, input int b);
        logic [63:0] a;
        a = base + 64'(b) * 64'd8;
        return {mem_word(a + 64'd4), mem_word(a)};
    endfunction

    // Sysbus memory: acks a request one cycle after seeing it, then streams 8 beats back-to-back.
    initial begin : responder
        logic req_seen;
        logic acc;
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b0;
        bus_resp    = 64'd0;
        bus_resptag = 13'd0;
        busy        = 1'b0;
        beat        = 0;
        line_addr   = 64'd0;
        forever begin
            @(negedge clk);
            req_seen = bus_reqcyc;
            acc      = bus_respcyc && bus_respack;
            @(posedge clk);
            #1;
            if (!reset) begin
                bus_reqack  = 1'b0;
                bus_respcyc = 1'b0;
                busy        = 1'b0;
                beat        = 0;
            end else if (bus_reqack) begin
                bus_reqack  = 1'b0;
                beat        = 0;
                bus_respcyc = 1'b1;
                bus_resp    = beat_data(line_addr, 0);
            end else if (acc) begin
                beat = beat + 1;
                if (beat == 8) begin
                    bus_respcyc = 1'b0;
                    busy        = 1'b0;
                end else begin
                    bus_resp = beat_data(line_addr, beat);
                end
            end else if (req_seen && !busy) begin
                bus_reqack = 1'b1;
                busy       = 1'b1;
                line_addr  = bus_req;
                req_q.push_back(bus_req);
                tag_q.push_back(64'(bus_reqtag));
            end
        end
    end

    // Record every decoder transfer (valid & ready at the coming edge).
    initial begin : collector
        forever begin
            @(negedge clk);
            if (reset && insn_valid && insn_ready) begin
                pcs.push_back(insn_pc);
                ins.push_back(64'(insn));
            end
        end
    end

    task automatic apply_reset(input logic [63:0] e, input logic chk_outs);
        reset          = 1'b0;
        entry          = e;
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;
        repeat (2) @(posedge clk);
        #2;
        if (chk_outs) begin
            check_eq("rst_insn_valid", 64'(insn_valid), 64'd0);
            check_eq("rst_halted", 64'(halted), 64'd0);
            check_eq("rst_reqcyc", 64'(bus_reqcyc), 64'd0);
            check_eq("rst_respack", 64'(bus_respack), 64'd0);
            check_eq("rst_req", bus_req, 64'd0);
            check_eq("rst_reqtag", 64'(bus_reqtag), 64'd0);
            check_eq("rst_insn", 64'(insn), 64'd0);
            check_eq("rst_insn_pc", insn_pc, 64'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        req_q.delete();
        tag_q.delete();
        pcs.delete();
        ins.delete();
    endtask

    task automatic wait_xfers(input string tag, input int n);
        int c;
        c = 0;
        while (pcs.size() < n && c < 2000) begin
            @(posedge clk);
            c++;
        end
        #2;
        check_eq(tag, 64'(pcs.size() >= n), 64'd1);
    endtask

    task automatic pulse_redirect(input logic [63:0] pc);
        redirect_pc    = pc;
        redirect_valid = 1'b1;
        @(posedge clk);
        #2;
        redirect_valid = 1'b0;
    endtask

    task automatic wait_beat(input int b);
        int c;
        c = 0;
        while (!(busy && bus_respcyc && beat == b && req_q.size() == 1) && c < 500) begin
            @(posedge clk);
            #2;
            c++;
        end
        check_eq("wait_beat", 64'(beat), 64'(b));
    endtask

    initial begin
        reset          = 1'b0;
        entry          = 64'h1000;
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;
        insn_ready     = 1'b1;

        // 1: aligned entry, 16 sequential words from one line
        apply_reset(64'h1000, 1'b1);
        wait_xfers("t1_xfers", 16);
        check_eq("t1_req0", req_q.size() > 0 ? req_q[0] : 64'hDEAD, 64'h1000);
        check_eq("t1_tag0", tag_q.size() > 0 ? tag_q[0] : 64'hDEAD, 64'h1100);
        for (int i = 0; i < 16 && i < pcs.size(); i++) begin
            check_eq($sformatf("t1_pc%0d", i), pcs[i], 64'h1000 + 64'(i) * 64'd4);
            check_eq($sformatf("t1_insn%0d", i), ins[i], 64'(i + 1));
        end
        check_eq("t1_halted", 64'(halted), 64'd0);

        // 2: mid-line entry drops the two low words
        apply_reset(64'h1008, 1'b0);
        wait_xfers("t2_xfers", 15);
        check_eq("t2_req0", req_q.size() > 0 ? req_q[0] : 64'hDEAD, 64'h1000);
        for (int i = 0; i < 14 && i < pcs.size(); i++) begin
            check_eq($sformatf("t2_pc%0d", i), pcs[i], 64'h1008 + 64'(i) * 64'd4);
            check_eq($sformatf("t2_insn%0d", i), ins[i], 64'(i + 3));
        end
        check_eq("t2_pc14", pcs.size() > 14 ? pcs[14] : 64'hDEAD, 64'h1040);

        // 3: decoder stalled, FIFO fills with two lines, head held stable
        insn_ready = 1'b0;
        apply_reset(64'h1000, 1'b0);
        repeat (40) @(posedge clk);
        #2;
        check_eq("t3_valid", 64'(insn_valid), 64'd1);
        check_eq("t3_pc_hold", insn_pc, 64'h1000);
        check_eq("t3_insn_hold", 64'(insn), 64'd1);
        check_eq("t3_nreq", 64'(req_q.size()), 64'd2);
        check_eq("t3_reqcyc", 64'(bus_reqcyc), 64'd0);
        repeat (5) @(posedge clk);
        #2;
        check_eq("t3_pc_hold2", insn_pc, 64'h1000);
        check_eq("t3_nreq2", 64'(req_q.size()), 64'd2);
        insn_ready = 1'b1;
        wait_xfers("t3_xfers", 40);
        for (int i = 0; i < 40 && i < pcs.size(); i++) begin
            check_eq($sformatf("t3_pc%0d", i), pcs[i], 64'h1000 + 64'(i) * 64'd4);
            check_eq($sformatf("t3_insn%0d", i), ins[i], 64'(i + 1));
        end

        // 4: redirect during beat 3 of the first burst
        apply_reset(64'h1000, 1'b0);
        wait_beat(3);
        pulse_redirect(64'h2000);
        check_eq("t4_flush_valid", 64'(insn_valid), 64'd0);
        pcs.delete();
        ins.delete();
        wait_xfers("t4_xfers", 1);
        check_eq("t4_req1", req_q.size() > 1 ? req_q[1] : 64'hDEAD, 64'h2000);
        check_eq("t4_pc0", pcs.size() > 0 ? pcs[0] : 64'hDEAD, 64'h2000);
        check_eq("t4_insn0", ins.size() > 0 ? ins[0] : 64'hDEAD, 64'h401);

        // 5: zero word at 0x1010 halts after four instructions
        zero_addr = 64'h1010;
        apply_reset(64'h1000, 1'b0);
        repeat (60) @(posedge clk);
        #2;
        check_eq("t5_nxfer", 64'(pcs.size()), 64'd4);
        for (int i = 0; i < 4 && i < pcs.size(); i++) begin
            check_eq($sformatf("t5_pc%0d", i), pcs[i], 64'h1000 + 64'(i) * 64'd4);
        end
        check_eq("t5_halted", 64'(halted), 64'd1);
        check_eq("t5_nreq", 64'(req_q.size()), 64'd1);
        check_eq("t5_reqcyc", 64'(bus_reqcyc), 64'd0);
        pulse_redirect(64'h3000);
        check_eq("t5_unhalt", 64'(halted), 64'd0);
        pcs.delete();
        ins.delete();
        wait_xfers("t5_xfers", 1);
        check_eq("t5_req1", req_q.size() > 1 ? req_q[1] : 64'hDEAD, 64'h3000);
        check_eq("t5_pc0", pcs.size() > 0 ? pcs[0] : 64'hDEAD, 64'h3000);
        check_eq("t5_insn0", ins.size() > 0 ? ins[0] : 64'hDEAD, 64'h801);
        zero_addr = '1;

        // 6: asynchronous reset in the middle of a burst
        apply_reset(64'h1000, 1'b0);
        wait_beat(4);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("t6_insn_valid", 64'(insn_valid), 64'd0);
        check_eq("t6_reqcyc", 64'(bus_reqcyc), 64'd0);
        check_eq("t6_respack", 64'(bus_respack), 64'd0);
        check_eq("t6_req", bus_req, 64'd0);
        check_eq("t6_reqtag", 64'(bus_reqtag), 64'd0);
        check_eq("t6_insn_pc", insn_pc, 64'd0);
        check_eq("t6_insn", 64'(insn), 64'd0);
        apply_reset(64'h1000, 1'b0);
        wait_xfers("t6_xfers", 1);
        check_eq("t6_req0", req_q.size() > 0 ? req_q[0] : 64'hDEAD, 64'h1000);
        check_eq("t6_pc0", pcs.size() > 0 ? pcs[0] : 64'hDEAD, 64'h1000);
        check_eq("t6_insn0", ins.size() > 0 ? ins[0] : 64'hDEAD, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
